// File: rtl/hamming12_pkg.sv
// Shared definitions for the (12,4) code: widths, generator rows, encoder, tx FSM states.
// The decoder regenerates its codeword table from enc12 so both ends always agree.
package hamming12_pkg;

    localparam int HAM_MSG_W = 4;
    localparam int HAM_CW_W  = 12;

    localparam logic [HAM_CW_W-1:0] HAM_G0 = 12'h03B;
    localparam logic [HAM_CW_W-1:0] HAM_G1 = 12'h0EC;
    localparam logic [HAM_CW_W-1:0] HAM_G2 = 12'h3B0;
    localparam logic [HAM_CW_W-1:0] HAM_G3 = 12'hEC0;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    function automatic logic [HAM_CW_W-1:0] enc12(input logic [HAM_MSG_W-1:0] m);
        logic [HAM_CW_W-1:0] cw;
        cw = '0;
        if (m[0]) cw = cw ^ HAM_G0;
        if (m[1]) cw = cw ^ HAM_G1;
        if (m[2]) cw = cw ^ HAM_G2;
        if (m[3]) cw = cw ^ HAM_G3;
        return cw;
    endfunction

endpackage

// File: rtl/hamming12_piso.sv
// 12-bit parallel-in serial-out stage with valid/ready output and a last-bit flag.
// Holds the tx FSM; its state is exported on state_o for observation.
module hamming12_piso
    import hamming12_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [HAM_CW_W-1:0] data_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic                bit_o,
    output logic                last_o,
    output tx_state_t           state_o
);

    localparam logic [3:0] LAST_CNT = 4'(HAM_CW_W - 1);

    tx_state_t           state_q, state_d;
    logic [HAM_CW_W-1:0] sr_q, sr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [HAM_CW_W-1:0] sr_shifted;

    assign sr_shifted = MSB_FIRST ? {sr_q[HAM_CW_W-2:0], 1'b0} : {1'b0, sr_q[HAM_CW_W-1:1]};

    // load_i is only raised by the wrapper when a load is legal (IDLE, or last bit handed off).
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            TX_IDLE: begin
                if (load_i) begin
                    state_d = TX_SHIFT;
                    sr_d    = data_i;
                    cnt_d   = '0;
                end
            end
            TX_SHIFT: begin
                if (ready_i) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (load_i) begin
                            sr_d = data_i;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        sr_d  = sr_shifted;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = (state_q == TX_SHIFT);
    assign last_o  = (state_q == TX_SHIFT) && (cnt_q == LAST_CNT);
    assign bit_o   = (state_q == TX_SHIFT) ? (MSB_FIRST ? sr_q[HAM_CW_W-1] : sr_q[0]) : 1'b0;
    assign state_o = state_q;

endmodule

// File: rtl/hamming12_encoder_tx.sv
// Encodes accepted 4-bit messages into (12,4) codewords and serialises them onto the channel.
// Optional one-shot error injection is enabled by defining HAMMING12_ERR_INJ_EN.
module hamming12_encoder_tx
    import hamming12_pkg::*;
#(
    parameter int MSG_W     = 4,
    parameter int CW_W      = 12,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] in_msg,
    output logic             cw_valid,
    output logic [CW_W-1:0]  codeword,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_bit,
    output logic             tx_last
`ifdef HAMMING12_ERR_INJ_EN
    ,
    input  logic [CW_W-1:0]  err_mask,
    input  logic             err_arm
`endif
);

    if (MSG_W != HAM_MSG_W || CW_W != HAM_CW_W) begin : g_width_check
        $error("hamming12_encoder_tx: MSG_W/CW_W are fixed at 4/12 by the code");
    end

    tx_state_t       tx_state;
    logic            accept;
    logic [CW_W-1:0] inj_mask;
    logic [CW_W-1:0] enc_cw;
    logic [CW_W-1:0] codeword_q, codeword_d;
    logic            cw_valid_q, cw_valid_d;

    // Handshake: a message moves when in_valid && in_ready at a rising edge; a channel bit
    // moves when tx_valid && tx_ready. in_ready never depends on in_valid.
    assign in_ready = (tx_state == TX_IDLE) || (tx_last && tx_ready);
    assign accept   = in_valid && in_ready;
    assign enc_cw   = enc12(in_msg) ^ inj_mask;

`ifdef HAMMING12_ERR_INJ_EN
    logic [CW_W-1:0] mask_q, mask_d;

    // An arm in the accept cycle takes effect on that very accept.
    assign inj_mask = err_arm ? err_mask : mask_q;

    always_comb begin
        mask_d = mask_q;
        if (err_arm) mask_d = err_mask;
        if (accept)  mask_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) mask_q <= '0;
        else     mask_q <= mask_d;
    end
`else
    assign inj_mask = '0;
`endif

    always_comb begin
        codeword_d = codeword_q;
        cw_valid_d = accept;
        if (accept) codeword_d = enc_cw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            codeword_q <= '0;
            cw_valid_q <= 1'b0;
        end else begin
            codeword_q <= codeword_d;
            cw_valid_q <= cw_valid_d;
        end
    end

    assign codeword = codeword_q;
    assign cw_valid = cw_valid_q;

    hamming12_piso #(
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .data_i  (enc_cw),
        .ready_i (tx_ready),
        .valid_o (tx_valid),
        .bit_o   (tx_bit),
        .last_o  (tx_last),
        .state_o (tx_state)
    );

endmodule

// File: tb/tb_hamming12_encoder_tx.sv
// Bench for hamming12_encoder_tx: reference codewords from the generator-row rule, frames
// reassembled from the serial channel and decoded by exhaustive minimum distance.
module tb_hamming12_encoder_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_msg;
    logic        cw_valid;
    logic [11:0] codeword;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_bit;
    logic        tx_last;
`ifdef HAMMING12_ERR_INJ_EN
    logic [11:0] err_mask;
    logic        err_arm;
`endif

    hamming12_encoder_tx dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_msg   (in_msg),
        .cw_valid (cw_valid),
        .codeword (codeword),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_bit   (tx_bit),
        .tx_last  (tx_last)
`ifdef HAMMING12_ERR_INJ_EN
        ,
        .err_mask (err_mask),
        .err_arm  (err_arm)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    localparam logic [11:0] GEN [4] = '{12'h03B, 12'h0EC, 12'h3B0, 12'hEC0};
    localparam logic [11:0] TBL [16] = '{12'h000, 12'h03B, 12'h0EC, 12'h0D7,
                                         12'h3B0, 12'h38B, 12'h35C, 12'h367,
                                         12'hEC0, 12'hEFB, 12'hE2C, 12'hE17,
                                         12'hD70, 12'hD4B, 12'hD9C, 12'hDA7};

    function automatic logic [11:0] ref_enc(input logic [3:0] m);
        logic [11:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++) if (m[i]) acc = acc ^ GEN[i];
        return acc;
    endfunction

    function automatic logic [3:0] md_decode(input logic [11:0] r);
        int         best_d;
        logic [3:0] best;
        best_d = 99;
        best   = '0;
        for (int c = 0; c < 16; c++) begin
            if ($countones(r ^ ref_enc(4'(c))) < best_d) begin
                best_d = $countones(r ^ ref_enc(4'(c)));
                best   = 4'(c);
            end
        end
        return best;
    endfunction

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];
    logic [3:0]  msg_q[$];
    logic [11:0] rx_q[$];
    int          rx_len_q[$];
    logic [11:0] exp_mask = '0;
    int          bp_mode = 0;      // 0: ready high, 1: random, 2: tx_ready_man
    logic        tx_ready_man = 1'b1;

    always @(posedge clk) begin
        #2;
        if (bp_mode == 0)      tx_ready = 1'b1;
        else if (bp_mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
        else                   tx_ready = tx_ready_man;
    end

    // Channel monitor: rebuild each frame MSB-first from handshaken bits.
    logic [11:0] mon_acc = '0;
    int          mon_hs = 0;
    always @(negedge clk) begin
        if (rst) begin
            mon_acc = '0;
            mon_hs  = 0;
        end else if (tx_valid && tx_ready) begin
            mon_acc = {mon_acc[10:0], tx_bit};
            mon_hs++;
            if (tx_last) begin
                rx_q.push_back(mon_acc);
                rx_len_q.push_back(mon_hs);
                mon_acc = '0;
                mon_hs  = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+2; returns at posedge+2 of the cycle after the accept.
    task automatic send_msg(input logic [3:0] m);
        int w;
        in_msg   = m;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_timeout: in_ready=%b required=1 msg=%h", in_ready, m);
        end
        exp_q.push_back(ref_enc(m) ^ exp_mask);
        msg_q.push_back(m);
        exp_mask = '0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_msg   = 4'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int w;
        w = 0;
        while ((tx_valid === 1'b1 || rx_q.size() < exp_q.size()) && w < 400) begin
            @(negedge clk);
            w++;
        end
        ok = (w < 400);
        @(posedge clk);
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got=%b want=1", in_ready); end
        n_cmp++;
        if (cw_valid !== 1'b0 || codeword !== 12'h000) begin
            n_bad++; $display("FAIL reset_codeword: got=%b/%h want=0/000", cw_valid, codeword);
        end
        n_cmp++;
        if (tx_valid !== 1'b0 || tx_bit !== 1'b0 || tx_last !== 1'b0) begin
            n_bad++; $display("FAIL reset_tx: got v=%b b=%b l=%b want 0/0/0", tx_valid, tx_bit, tx_last);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_first_frame();
        logic [11:0] seq;
        logic [11:0] got;
        bit          ok;
        seq = 12'b0000_0011_1011;
        bp_mode = 0;
        send_msg(4'h1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_bit !== seq[11-k] || tx_last !== 1'(k == 11)) begin
                n_bad++;
                $display("FAIL first_bit%0d: got v=%b b=%b l=%b want 1/%b/%b", k, tx_valid, tx_bit, tx_last, seq[11-k], k == 11);
            end
            n_cmp++;
            if (in_ready !== 1'(k == 11)) begin
                n_bad++; $display("FAIL first_in_ready%0d: got=%b want=%b", k, in_ready, k == 11);
            end
            if (k < 2) begin
                n_cmp++;
                if (cw_valid !== 1'(k == 0) || codeword !== 12'h03B) begin
                    n_bad++; $display("FAIL first_cw%0d: got=%b/%h want=%b/03B", k, cw_valid, codeword, k == 0);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL first_end: tx_valid=%b want=0", tx_valid); end
        wait_idle(ok);
        n_cmp++;
        if (!ok || rx_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++; $display("FAIL first_drain: rx=%0d exp=%0d want 1/1", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front();
            n_cmp++;
            if (got !== exp_q.pop_front() || rx_len_q.pop_front() != 12) begin
                n_bad++; $display("FAIL first_frame: got=%h want=03B", got);
            end
        end
        rx_q.delete(); rx_len_q.delete(); exp_q.delete(); msg_q.delete();
    endtask

    task automatic test_sweep();
        logic [11:0] got, want;
        logic [3:0]  m;
        int          len;
        bit          ok;
        bp_mode = 1;
        for (int i = 0; i < 16; i++) begin
            idle_cycles($urandom_range(0, 2));
            send_msg(4'(i));
            @(negedge clk);
            n_cmp++;
            if (cw_valid !== 1'b1 || codeword !== TBL[i]) begin
                n_bad++; $display("FAIL sweep_cw%0d: got=%b/%h want=1/%h", i, cw_valid, codeword, TBL[i]);
            end
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL sweep_drain: rx=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front(); len = rx_len_q.pop_front(); m = msg_q.pop_front();
            n_cmp++;
            if (got !== want || len != 12 || md_decode(got) !== m) begin
                n_bad++; $display("FAIL sweep_frame: got=%h len=%0d dec=%h want=%h len=12 dec=%h", got, len, md_decode(got), want, m);
            end
        end
        rx_q.delete(); rx_len_q.delete(); exp_q.delete(); msg_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [11:0] got, want;
        int          w;
        bit          ok;
        bp_mode = 0;
        idle_cycles(2);
        fork
            begin
                send_msg(4'h3);
                send_msg(4'hC);
            end
            begin
                w = 0;
                @(negedge clk);
                while (tx_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
                for (int i = 0; i < 24; i++) begin
                    n_cmp++;
                    if (tx_valid !== 1'b1 || in_ready !== 1'(i == 11 || i == 23) || tx_last !== 1'(i == 11 || i == 23)) begin
                        n_bad++;
                        $display("FAIL b2b_cycle%0d: got v=%b r=%b l=%b want 1/%b/%b", i, tx_valid, in_ready, tx_last, i == 11 || i == 23, i == 11 || i == 23);
                    end
                    if (i == 12) begin
                        n_cmp++;
                        if (cw_valid !== 1'b1 || codeword !== 12'hD70) begin
                            n_bad++; $display("FAIL b2b_cw2: got=%b/%h want=1/D70", cw_valid, codeword);
                        end
                    end
                    @(negedge clk);
                end
                n_cmp++;
                if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: tx_valid=%b want=0", tx_valid); end
            end
        join
        wait_idle(ok);
        n_cmp++;
        if (!ok || rx_q.size() != 2 || exp_q.size() != 2) begin
            n_bad++; $display("FAIL b2b_drain: rx=%0d exp=%0d want 2/2", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            n_cmp++;
            if (got !== want || rx_len_q.pop_front() != 12) begin
                n_bad++; $display("FAIL b2b_frame: got=%h want=%h", got, want);
            end
        end
        rx_q.delete(); rx_len_q.delete(); exp_q.delete(); msg_q.delete();
    endtask

    task automatic test_backpressure();
        logic [11:0] cw, got;
        int          hsk, stall, held5, cyc;
        bit          ok;
        cw = 12'h0EC;
        bp_mode = 2;
        tx_ready_man = 1'b1;
        idle_cycles(2);
        send_msg(4'h2);
        hsk = 0; stall = 0; held5 = 0; cyc = 0;
        while (hsk < 12 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_bit !== cw[11-hsk] || tx_last !== 1'(hsk == 11)) begin
                n_bad++;
                $display("FAIL bp_bit%0d: got v=%b b=%b l=%b want 1/%b/%b", hsk, tx_valid, tx_bit, tx_last, cw[11-hsk], hsk == 11);
            end
            if (hsk == 5) held5++;
            if (tx_ready) hsk++;
            tx_ready_man = !(hsk == 5 && stall < 3);
            if (!tx_ready_man) stall++;
        end
        n_cmp++;
        if (held5 != 4 || cyc != 15) begin
            n_bad++; $display("FAIL bp_hold: bit5 cycles=%0d frame cycles=%0d want 4/15", held5, cyc);
        end
        tx_ready_man = 1'b1;
        bp_mode = 0;
        wait_idle(ok);
        n_cmp++;
        if (!ok || rx_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++; $display("FAIL bp_drain: rx=%0d exp=%0d want 1/1", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front();
            n_cmp++;
            if (got !== 12'h0EC || got !== exp_q.pop_front() || rx_len_q.pop_front() != 12) begin
                n_bad++; $display("FAIL bp_frame: got=%h want=0EC", got);
            end
        end
        rx_q.delete(); rx_len_q.delete(); exp_q.delete(); msg_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [11:0] got;
        bit          ok;
        bp_mode = 0;
        idle_cycles(2);
        send_msg(4'h9);
        idle_cycles(7);
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(msg_q.pop_back());
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b0 || in_ready !== 1'b1 || codeword !== 12'h000 || cw_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: got v=%b r=%b cw=%h cwv=%b want 0/1/000/0", tx_valid, in_ready, codeword, cw_valid);
        end
        @(posedge clk);
        #2;
        send_msg(4'h1);
        @(negedge clk);
        n_cmp++;
        if (cw_valid !== 1'b1 || codeword !== 12'h03B) begin
            n_bad++; $display("FAIL rst_mid_cw: got=%b/%h want=1/03B", cw_valid, codeword);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok || rx_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++; $display("FAIL rst_mid_drain: rx=%0d exp=%0d want 1/1", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front();
            n_cmp++;
            if (got !== 12'h03B || got !== exp_q.pop_front() || rx_len_q.pop_front() != 12) begin
                n_bad++; $display("FAIL rst_mid_frame: got=%h want=03B", got);
            end
        end
        rx_q.delete(); rx_len_q.delete(); exp_q.delete(); msg_q.delete();
    endtask

    task automatic test_random();
        logic [11:0] got, want;
        logic [3:0]  m;
        int          len;
        bit          ok;
        bp_mode = 1;
        for (int i = 0; i < 24; i++) begin
            idle_cycles($urandom_range(0, 3));
            m = 4'($urandom_range(0, 15));
            send_msg(m);
            @(negedge clk);
            n_cmp++;
            if (cw_valid !== 1'b1 || codeword !== ref_enc(m)) begin
                n_bad++; $display("FAIL rand_cw%0d: got=%b/%h want=1/%h", i, cw_valid, codeword, ref_enc(m));
            end
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL rand_drain: rx=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front(); len = rx_len_q.pop_front(); m = msg_q.pop_front();
            n_cmp++;
            if (got !== want || len != 12 || md_decode(got) !== m) begin
                n_bad++; $display("FAIL rand_frame: got=%h len=%0d want=%h msg=%h", got, len, want, m);
            end
        end
        rx_q.delete(); rx_len_q.delete(); exp_q.delete(); msg_q.delete();
        bp_mode = 0;
    endtask

`ifdef HAMMING12_ERR_INJ_EN
    task automatic test_err_inj();
        logic [11:0] got, want;
        bit          ok;
        bp_mode = 0;
        idle_cycles(2);
        err_mask = 12'h001;
        err_arm  = 1'b1;
        idle_cycles(1);
        err_arm  = 1'b0;
        err_mask = 12'($urandom);
        exp_mask = 12'h001;
        send_msg(4'h0);
        @(negedge clk);
        n_cmp++;
        if (codeword !== 12'h001) begin n_bad++; $display("FAIL inj_cw1: got=%h want=001", codeword); end
        @(posedge clk);
        #2;
        send_msg(4'h0);
        @(negedge clk);
        n_cmp++;
        if (codeword !== 12'h000) begin n_bad++; $display("FAIL inj_cw2: got=%h want=000", codeword); end
        @(posedge clk);
        #2;
        err_mask = 12'h800;
        err_arm  = 1'b1;
        exp_mask = 12'h800;
        send_msg(4'h5);
        err_arm  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (codeword !== 12'hB8B) begin n_bad++; $display("FAIL inj_cw3: got=%h want=B8B", codeword); end
        wait_idle(ok);
        n_cmp++;
        if (!ok || rx_q.size() != 3 || exp_q.size() != 3) begin
            n_bad++; $display("FAIL inj_drain: rx=%0d exp=%0d want 3/3", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            n_cmp++;
            if (got !== want || rx_len_q.pop_front() != 12 || md_decode(got) !== msg_q.pop_front()) begin
                n_bad++; $display("FAIL inj_frame: got=%h want=%h", got, want);
            end
        end
        rx_q.delete(); rx_len_q.delete(); exp_q.delete(); msg_q.delete();
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_msg   = '0;
`ifdef HAMMING12_ERR_INJ_EN
        err_mask = '0;
        err_arm  = 1'b0;
`endif
        test_reset();
        test_first_frame();
        test_sweep();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_random();
`ifdef HAMMING12_ERR_INJ_EN
        test_err_inj();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
